// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified-memory arbiter: response-owner encoding,
// default starvation limit and the SRAM control values used when idle.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } own_t;

  localparam int MAX_WAIT_DEFAULT = 4;

  localparam logic        MEM_CSN_IDLE = 1'b1;
  localparam logic        MEM_WEN_IDLE = 1'b1;
  localparam logic [31:0] MEM_DI_IDLE  = 32'h0;
  localparam logic [3:0]  MEM_BE_IDLE  = 4'b0000;

endpackage

// File: rtl/arb_wait_counter.sv
// 4-bit saturating counter tracking consecutive denied fetch cycles.
module arb_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic       sat,
  output logic [3:0] count
);

  // Clear has priority over increment; sat freezes the count at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (inc && !sat) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between the core fetch and data ports: data has
// priority, a starvation counter forces a fetch grant after MAX_WAIT denials.
module unified_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AWIDTH   = 12,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [31:0]       I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [31:0]       I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [31:0]       D_ADDR,
  input  logic [31:0]       D_WDATA,
  input  logic [3:0]        D_BE,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [31:0]       D_RDATA,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic [31:0]       MEM_DI,
  output logic [3:0]        MEM_BE,
  input  logic [31:0]       MEM_DOUT
);

  logic [3:0] wait_cnt;
  logic       at_limit;
  logic       grant_i;
  logic       grant_d;
  own_t       rsp_own;

  assign at_limit = (wait_cnt == 4'(MAX_WAIT));

  // Data wins contention unless the fetch side has been starved to the limit.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!RST) begin
      if (I_REQ && (!D_REQ || at_limit)) begin
        grant_i = 1'b1;
      end else if (D_REQ) begin
        grant_d = 1'b1;
      end
    end
  end

  arb_wait_counter u_wait_counter (
    .clk   (CLK),
    .rst   (RST),
    .inc   (I_REQ && !grant_i),
    .clr   (grant_i || !I_REQ),
    .sat   (at_limit),
    .count (wait_cnt)
  );

  always_comb begin
    MEM_CSN  = MEM_CSN_IDLE;
    MEM_WEN  = MEM_WEN_IDLE;
    MEM_ADDR = '0;
    MEM_DI   = MEM_DI_IDLE;
    MEM_BE   = MEM_BE_IDLE;
    if (grant_i) begin
      MEM_CSN  = 1'b0;
      MEM_ADDR = I_ADDR[AWIDTH+1:2];
    end else if (grant_d) begin
      MEM_CSN  = 1'b0;
      MEM_ADDR = D_ADDR[AWIDTH+1:2];
      if (D_WE) begin
        MEM_WEN = 1'b0;
        MEM_DI  = D_WDATA;
        MEM_BE  = D_BE;
      end
    end
  end

  // The SRAM answers one cycle later, so remember who the read belongs to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_own <= OWN_NONE;
    end else if (grant_i) begin
      rsp_own <= OWN_I;
    end else if (grant_d && !D_WE) begin
      rsp_own <= OWN_D;
    end else begin
      rsp_own <= OWN_NONE;
    end
  end

  assign I_GNT    = grant_i;
  assign D_GNT    = grant_d;
  assign I_RVALID = (rsp_own == OWN_I) && !RST;
  assign D_RVALID = (rsp_own == OWN_D) && !RST;
  assign I_RDATA  = MEM_DOUT;
  assign D_RDATA  = MEM_DOUT;

  // Byte-offset and out-of-range address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{I_ADDR[31:AWIDTH+2], I_ADDR[1:0],
                              D_ADDR[31:AWIDTH+2], D_ADDR[1:0]};

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed plus randomized bench for unified_mem_arbiter, checked against a
// cycle-level behavioural model and a word-array memory reference.
module tb_unified_mem_arbiter;

  localparam int AWIDTH   = 12;
  localparam int MAX_WAIT = 4;
  localparam int WORDS    = 1 << AWIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_csn;
  logic              mem_wen;
  logic [AWIDTH-1:0] mem_addr;
  logic [31:0]       mem_di;
  logic [3:0]        mem_be;
  logic [31:0]       mem_dout = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_wait = 0;
  int          m_own  = 0;
  logic [31:0] m_data = 32'h0;
  logic        last_i_gnt = 1'b0;
  logic        last_d_gnt = 1'b0;
  logic [31:0] ref_mem [WORDS];

  logic [31:0] sram    [WORDS];
  bit          written [WORDS];

  always #5 clk = ~clk;

  unified_mem_arbiter #(.AWIDTH(AWIDTH), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(clk), .RST(rst),
    .I_REQ(i_req), .I_ADDR(i_addr), .I_GNT(i_gnt), .I_RVALID(i_rvalid), .I_RDATA(i_rdata),
    .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata), .D_BE(d_be),
    .D_GNT(d_gnt), .D_RVALID(d_rvalid), .D_RDATA(d_rdata),
    .MEM_CSN(mem_csn), .MEM_WEN(mem_wen), .MEM_ADDR(mem_addr), .MEM_DI(mem_di),
    .MEM_BE(mem_be), .MEM_DOUT(mem_dout)
  );

  function automatic logic [31:0] init_word(input logic [AWIDTH-1:0] a);
    if (a == AWIDTH'(4)) return 32'hDEADBEEF;
    return ({20'h0, a} * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // Single-port SRAM with one-cycle read latency; unwritten words hold init_word.
  always @(posedge clk) begin
    logic [31:0] w;
    if (!mem_csn) begin
      w = written[mem_addr] ? sram[mem_addr] : init_word(mem_addr);
      if (!mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) w[8*b +: 8] = mem_di[8*b +: 8];
        sram[mem_addr]    <= w;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_dout <= w;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [3:0] dbe);
    rst = r; i_req = ir; i_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_be = dbe;
  endtask

  // Compare one cycle of DUT behaviour with the model, then advance the model past the edge.
  task automatic checkOutput(input string tag);
    logic             exp_i, exp_d, exp_ri, exp_rd;
    logic [AWIDTH-1:0] wi, wd, exp_addr;
    @(negedge clk);
    exp_i = 1'b0;
    exp_d = 1'b0;
    if (!rst) begin
      if (i_req && (!d_req || m_wait == MAX_WAIT)) exp_i = 1'b1;
      else if (d_req) exp_d = 1'b1;
    end
    wi = i_addr[AWIDTH+1:2];
    wd = d_addr[AWIDTH+1:2];
    exp_addr = exp_i ? wi : (exp_d ? wd : '0);
    exp_ri = !rst && (m_own == 1);
    exp_rd = !rst && (m_own == 2);

    check_val({tag, ".i_gnt"}, 32'(i_gnt), 32'(exp_i));
    check_val({tag, ".d_gnt"}, 32'(d_gnt), 32'(exp_d));
    check_val({tag, ".csn"}, 32'(mem_csn), 32'(!(exp_i || exp_d)));
    check_val({tag, ".wen"}, 32'(mem_wen), 32'(!(exp_d && d_we)));
    check_val({tag, ".addr"}, 32'(mem_addr), 32'(exp_addr));
    if (!exp_i && !exp_d) begin
      check_val({tag, ".di_idle"}, mem_di, 32'h0);
      check_val({tag, ".be_idle"}, 32'(mem_be), 32'h0);
    end
    if (exp_d && d_we) begin
      check_val({tag, ".di"}, mem_di, d_wdata);
      check_val({tag, ".be"}, 32'(mem_be), 32'(d_be));
    end
    check_val({tag, ".i_rvalid"}, 32'(i_rvalid), 32'(exp_ri));
    check_val({tag, ".d_rvalid"}, 32'(d_rvalid), 32'(exp_rd));
    if (exp_ri) check_val({tag, ".i_rdata"}, i_rdata, m_data);
    if (exp_rd) check_val({tag, ".d_rdata"}, d_rdata, m_data);

    last_i_gnt = exp_i;
    last_d_gnt = exp_d;
    if (rst) begin
      m_wait = 0;
      m_own  = 0;
    end else begin
      if (exp_i) begin
        m_own = 1; m_data = ref_mem[wi];
      end else if (exp_d && !d_we) begin
        m_own = 2; m_data = ref_mem[wd];
      end else begin
        m_own = 0;
      end
      if (exp_d && d_we)
        for (int b = 0; b < 4; b++)
          if (d_be[b]) ref_mem[wd][8*b +: 8] = d_wdata[8*b +: 8];
      if (exp_i || !i_req) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_i_first;
    for (int a = 0; a < WORDS; a++) ref_mem[a] = init_word(AWIDTH'(a));

    // Reset
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 4'h0);
    checkOutput("reset0");
    checkOutput("reset1");

    // Lone fetch of word 4
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 0, 0, 4'h0);
    checkOutput("fetch_gnt");
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 4'h0);
    checkOutput("fetch_rsp");

    // Data write then read back
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'b1111);
    checkOutput("dwrite");
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h20, 0, 4'b0000);
    checkOutput("dread_gnt");
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 4'h0);
    checkOutput("dread_rsp");
    check_val("dread_value_model", m_data, 32'h12345678);

    // Continuous contention: D for MAX_WAIT cycles, then forced I, then D again
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 0, 4'h0);
    n_i_first = -1;
    for (int c = 0; c < 8; c++) begin
      checkOutput("contend");
      if (last_i_gnt && n_i_first < 0) n_i_first = c;
    end
    check_val("contend_first_i_cycle", 32'(n_i_first), 32'(MAX_WAIT));

    // Alternating fetch / data reads
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0) applyStimulus(1'b0, 1'b1, 32'(c * 8 + 4), 1'b0, 1'b0, 0, 0, 4'h0);
      else            applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 32'(c * 8 + 64), 0, 4'h0);
      checkOutput("alternate");
    end

    // Reset right after a fetch grant suppresses its response
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 0, 0, 4'h0);
    checkOutput("pre_reset_gnt");
    applyStimulus(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 0, 4'h0);
    checkOutput("reset_mid");
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 0, 0, 4'h0);
    checkOutput("post_reset_gnt");
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 4'h0);
    checkOutput("post_reset_rsp");

    // Fetch denied 3 cycles, drops once, then contention restarts from zero
    applyStimulus(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h40, 0, 4'h0);
    for (int c = 0; c < 3; c++) checkOutput("deny");
    applyStimulus(1'b0, 1'b0, 32'h30, 1'b1, 1'b0, 32'h40, 0, 4'h0);
    checkOutput("drop");
    applyStimulus(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h40, 0, 4'h0);
    checkOutput("rerequest");
    check_val("rerequest_d_wins", 32'(last_d_gnt), 32'h1);

    // Randomized traffic with held requests, occasional drops and resets
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 4'h0);
    for (int c = 0; c < 600; c++) begin
      if (last_i_gnt || !i_req) begin
        i_req  = ($urandom_range(0, 99) < 60);
        i_addr = $urandom;
      end else if ($urandom_range(0, 99) < 5) begin
        i_req = 1'b0;
      end
      if (last_d_gnt || !d_req) begin
        d_req   = ($urandom_range(0, 99) < 60);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = {$urandom_range(0, 31) == 0 ? 32'h10 : $urandom};
        d_wdata = $urandom;
        d_be    = 4'($urandom);
      end else if ($urandom_range(0, 99) < 5) begin
        d_req = 1'b0;
      end
      rst = ($urandom_range(0, 99) == 0);
      checkOutput("random");
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
